// File: rtl/dct16_pair.sv
// dct16_pair: 16-point 1-D DCT-II for 8-bit unsigned samples.
// The 16 samples arrive as 8 mirrored pairs (x[n], x[15-n]), one pair per clock.
// The 16 coefficients leave as 8 pairs (X[2m], X[2m+1]) in signed Q8.
// Build option: define DCT_ROUND_EN to round each presented coefficient to a
// whole number in Q8 (halves round toward +inf). Without it the raw Q8
// accumulator value is presented.
module dct16_pair (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [7:0]  INPUT_A,
    input  logic [7:0]  INPUT_B,
    output logic [23:0] OUTPUT_A,
    output logic [23:0] OUTPUT_B,
    output logic [3:0]  INDEX_A,
    output logic [3:0]  INDEX_B,
    output logic        output_en
);

    localparam int unsigned NPT   = 16;
    localparam int unsigned ACC_W = 24;
    localparam int unsigned CNT_W = 3;
    localparam int unsigned PRD_W = 20;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_OUT  = 2'd2
    } state_t;

    // round(sqrt(2/16) * cos(idx*pi/32) * 256) for idx = 0..16
    function automatic logic [6:0] cos_mag(input logic [4:0] idx);
        logic [6:0] mag;
        case (idx)
            5'd0:    mag = 7'd91;
            5'd1:    mag = 7'd90;
            5'd2:    mag = 7'd89;
            5'd3:    mag = 7'd87;
            5'd4:    mag = 7'd84;
            5'd5:    mag = 7'd80;
            5'd6:    mag = 7'd75;
            5'd7:    mag = 7'd70;
            5'd8:    mag = 7'd64;
            5'd9:    mag = 7'd57;
            5'd10:   mag = 7'd50;
            5'd11:   mag = 7'd43;
            5'd12:   mag = 7'd35;
            5'd13:   mag = 7'd26;
            5'd14:   mag = 7'd18;
            5'd15:   mag = 7'd9;
            default: mag = 7'd0;
        endcase
        return mag;
    endfunction

    // C[k][n] for n = 0..7: the cosine phase (2n+1)*k is taken mod 64 and
    // folded into the first quadrant so a 17-entry magnitude table suffices.
    function automatic logic signed [9:0] coef(input logic [3:0] k, input logic [2:0] n);
        logic [5:0]        phase;
        logic [5:0]        fold;
        logic [4:0]        idx;
        logic              neg;
        logic signed [9:0] mag;
        phase = {2'b00, n, 1'b1} * {2'b00, k};
        if (phase > 6'd32) begin
            fold = 6'(7'd64 - {1'b0, phase});
        end else begin
            fold = phase;
        end
        if (fold > 6'd16) begin
            neg = 1'b1;
            idx = 5'(6'd32 - fold);
        end else begin
            neg = 1'b0;
            idx = fold[4:0];
        end
        mag = $signed({3'b000, cos_mag(idx)});
        if (k == 4'd0) begin
            return 10'sd64;
        end
        return neg ? -mag : mag;
    endfunction

    // Value placed on the output bus for one accumulator
    function automatic logic [23:0] present(input logic [23:0] acc);
`ifdef DCT_ROUND_EN
        logic [23:0] r;
        r      = acc + 24'd128;
        r[7:0] = 8'd0;
        return r;
`else
        return acc;
`endif
    endfunction

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [ACC_W-1:0]   acc_q [NPT];
    logic [ACC_W-1:0]   acc_d [NPT];
    logic [23:0]        out_a_q, out_a_d;
    logic [23:0]        out_b_q, out_b_d;
    logic [3:0]         idx_a_q, idx_a_d;
    logic [3:0]         idx_b_q, idx_b_d;
    logic               oen_q, oen_d;

    logic [8:0]         pair_sum;
    logic [8:0]         pair_diff;
    logic signed [9:0]  sum_op;
    logic signed [9:0]  diff_op;

    // Even/odd folding of the incoming pair
    always_comb begin
        pair_sum  = {1'b0, INPUT_A} + {1'b0, INPUT_B};
        pair_diff = {1'b0, INPUT_A} - {1'b0, INPUT_B};
        sum_op    = $signed({1'b0, pair_sum});
        diff_op   = $signed({pair_diff[8], pair_diff});
    end

    // Next-state, accumulator update and output staging
    always_comb begin
        logic                    do_acc;
        logic                    clr_acc;
        logic [CNT_W-1:0]        pair_n;
        logic signed [9:0]       c;
        logic signed [PRD_W-1:0] prod;
        logic [ACC_W-1:0]        base;

        state_d = state_q;
        cnt_d   = cnt_q;
        out_a_d = 24'd0;
        out_b_d = 24'd0;
        idx_a_d = 4'd0;
        idx_b_d = 4'd0;
        oen_d   = 1'b0;
        do_acc  = 1'b0;
        clr_acc = 1'b0;
        pair_n  = cnt_q;
        c       = 10'sd0;
        prod    = '0;
        base    = '0;
        for (int k = 0; k < NPT; k++) begin
            acc_d[k] = acc_q[k];
        end

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    do_acc  = 1'b1;
                    clr_acc = 1'b1;
                    pair_n  = 3'd0;
                    cnt_d   = 3'd1;
                    state_d = ST_LOAD;
                end
            end
            ST_LOAD: begin
                do_acc = 1'b1;
                if (cnt_q == 3'd7) begin
                    cnt_d   = 3'd0;
                    state_d = ST_OUT;
                end else begin
                    cnt_d = 3'(cnt_q + 3'd1);
                end
            end
            ST_OUT: begin
                oen_d   = 1'b1;
                out_a_d = present(acc_q[{cnt_q, 1'b0}]);
                out_b_d = present(acc_q[{cnt_q, 1'b1}]);
                idx_a_d = {cnt_q, 1'b0};
                idx_b_d = {cnt_q, 1'b1};
                // Leaving after the last pair makes the following edge an IDLE
                // edge: it drops output_en and may already accept a new start.
                if (cnt_q == 3'd7) begin
                    cnt_d   = 3'd0;
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = 3'(cnt_q + 3'd1);
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = 3'd0;
            end
        endcase

        if (do_acc) begin
            for (int k = 0; k < NPT; k++) begin
                c    = coef(4'(k), pair_n);
                prod = c * ((k % 2 == 0) ? sum_op : diff_op);
                base = clr_acc ? 24'd0 : acc_q[k];
                acc_d[k] = base + {{(ACC_W - PRD_W){prod[PRD_W-1]}}, prod};
            end
        end
    end

    // State, accumulators and registered outputs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= 3'd0;
            out_a_q <= 24'd0;
            out_b_q <= 24'd0;
            idx_a_q <= 4'd0;
            idx_b_q <= 4'd0;
            oen_q   <= 1'b0;
            for (int k = 0; k < NPT; k++) begin
                acc_q[k] <= 24'd0;
            end
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            out_a_q <= out_a_d;
            out_b_q <= out_b_d;
            idx_a_q <= idx_a_d;
            idx_b_q <= idx_b_d;
            oen_q   <= oen_d;
            for (int k = 0; k < NPT; k++) begin
                acc_q[k] <= acc_d[k];
            end
        end
    end

    assign OUTPUT_A  = out_a_q;
    assign OUTPUT_B  = out_b_q;
    assign INDEX_A   = idx_a_q;
    assign INDEX_B   = idx_b_q;
    assign output_en = oen_q;

endmodule

// File: tb/tb_dct16_pair.sv
// Self-checking bench for dct16_pair: a real-arithmetic DCT-II model predicts
// every output cycle; literal values pin the model. Honours DCT_ROUND_EN.
module tb_dct16_pair;

    logic        clk;
    logic        reset;
    logic        start;
    logic [7:0]  in_a;
    logic [7:0]  in_b;
    logic [23:0] out_a;
    logic [23:0] out_b;
    logic [3:0]  idx_a;
    logic [3:0]  idx_b;
    logic        oen;

    dct16_pair dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .INPUT_A   (in_a),
        .INPUT_B   (in_b),
        .OUTPUT_A  (out_a),
        .OUTPUT_B  (out_b),
        .INDEX_A   (idx_a),
        .INDEX_B   (idx_b),
        .output_en (oen)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    localparam real PI = 3.14159265358979323846;
`ifdef DCT_ROUND_EN
    localparam int L_DC0   = 10240;
    localparam int L_IMP0  = 16384;
    localparam int L_IMP1  = 23040;
    localparam int L_RAMP0 = 11264;
    localparam real TOL    = 1.0;
`else
    localparam int L_DC0   = 10240;
    localparam int L_IMP0  = 16320;
    localparam int L_IMP1  = 22950;
    localparam int L_RAMP0 = 11264;
    localparam real TOL    = 0.5;
`endif

    typedef struct {
        int cyc;
        int m;
        int a;
        int b;
    } exp_t;

    exp_t expq[$];
    int   n_checks = 0;
    int   n_pass   = 0;
    int   cyc      = 0;
    int   smp  [16];
    int   expx [16];
    int   got  [16];

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    endtask

    function automatic int rnd(input real r);
        if (r >= 0.0) return int'($floor(r + 0.5));
        return -int'($floor(-r + 0.5));
    endfunction

    function automatic real ck(input int k);
        return (k == 0) ? 0.25 : $sqrt(2.0 / 16.0);
    endfunction

    // Coefficient as the transform defines it, over all 16 sample positions
    function automatic int coef(input int k, input int n);
        return rnd(ck(k) * $cos(PI * real'((2 * n + 1) * k) / 32.0) * 256.0);
    endfunction

    function automatic int present(input int v);
`ifdef DCT_ROUND_EN
        return (v + 128) & -256;
`else
        return v;
`endif
    endfunction

    function automatic real dct_ref(input int k);
        real s;
        s = 0.0;
        for (int n = 0; n < 16; n++) s += real'(smp[n]) * $cos(PI * real'((2 * n + 1) * k) / 32.0);
        return ck(k) * s;
    endfunction

    task automatic model();
        int s;
        for (int k = 0; k < 16; k++) begin
            s = 0;
            for (int n = 0; n < 16; n++) s += coef(k, n) * smp[n];
            expx[k] = present(s);
        end
    endtask

    // Called at a falling edge; start is sampled on the next rising edge (E0)
    task automatic run_block();
        int   e0;
        exp_t e;
        model();
        e0 = cyc + 1;
        for (int k = 0; k < 16; k++) got[k] = -99999999;
        for (int m = 0; m < 8; m++) begin
            e.cyc = e0 + 8 + m;
            e.m   = m;
            e.a   = expx[2 * m];
            e.b   = expx[2 * m + 1];
            expq.push_back(e);
        end
        for (int n = 0; n < 8; n++) begin
            start = (n == 0);
            in_a  = 8'(smp[n]);
            in_b  = 8'(smp[15 - n]);
            @(negedge clk);
        end
        start = 1'b0;
    endtask

    task automatic set_dc();
        for (int n = 0; n < 16; n++) smp[n] = 10;
    endtask

    task automatic set_impulse();
        for (int n = 0; n < 16; n++) smp[n] = 0;
        smp[0] = 255;
    endtask

    // Per-cycle comparison against the model's expected stream
    initial begin
        exp_t e;
        int   va;
        int   vb;
        forever begin
            @(posedge clk);
            cyc++;
            #1;
            if (expq.size() != 0 && expq[0].cyc == cyc) begin
                e  = expq.pop_front();
                va = 32'($signed(out_a));
                vb = 32'($signed(out_b));
                chk("output_en", int'(oen), 1);
                chk("index_a", int'(idx_a), 2 * e.m);
                chk("index_b", int'(idx_b), 2 * e.m + 1);
                chk("coef_a", va, e.a);
                chk("coef_b", vb, e.b);
                got[2 * e.m]     = va;
                got[2 * e.m + 1] = vb;
            end else begin
                chk("output_en_idle", int'(oen), 0);
                chk("outputs_idle", int'(out_a) | int'(out_b) | int'(idx_a) | int'(idx_b), 0);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        real err;
        reset = 1'b1;
        start = 1'b0;
        in_a  = 8'd0;
        in_b  = 8'd0;
        repeat (10) @(negedge clk);
        reset = 1'b0;

        // Inputs without start must not launch a block
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            in_a = 8'($urandom);
            in_b = 8'($urandom);
        end
        @(negedge clk);

        // DC level 10
        set_dc();
        run_block();
        chk("model_dc_x0", expx[0], L_DC0);
        repeat (10) @(negedge clk);
        chk("dc_x0", got[0], L_DC0);
        for (int k = 1; k < 16; k++) begin
            if (k % 2 == 1) chk("dc_odd_zero", got[k], 0);
            else chk("dc_even_small", int'(got[k] <= 80 && got[k] >= -80), 1);
        end

        // Impulse at x[0]
        set_impulse();
        run_block();
        chk("model_imp_x0", expx[0], L_IMP0);
        chk("model_imp_x1", expx[1], L_IMP1);
        repeat (10) @(negedge clk);
        chk("imp_x0", got[0], L_IMP0);
        chk("imp_x1", got[1], L_IMP1);

        // Ramp/bell data, with a start pulse during the output stream
        smp = '{1, 3, 5, 7, 9, 17, 19, 21, 22, 18, 18, 16, 8, 6, 4, 2};
        run_block();
        chk("model_ramp_x0", expx[0], L_RAMP0);
        repeat (3) @(negedge clk);
        start = 1'b1;
        in_a  = 8'd77;
        in_b  = 8'd5;
        @(negedge clk);
        start = 1'b0;
        repeat (25) @(negedge clk);
        chk("ramp_x0", got[0], L_RAMP0);
        for (int k = 0; k < 16; k++) begin
            err = real'(got[k]) / 256.0 - dct_ref(k);
            if (err < 0.0) err = -err;
            chk("ramp_vs_real_dct", int'(err <= TOL), 1);
        end

        // Reset during LOAD after pair 4 discards the block
        set_dc();
        for (int n = 0; n < 5; n++) begin
            start = (n == 0);
            in_a  = 8'(smp[n]);
            in_b  = 8'(smp[15 - n]);
            @(negedge clk);
        end
        start = 1'b0;
        reset = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        repeat (12) @(negedge clk);
        run_block();
        repeat (10) @(negedge clk);
        chk("dc_after_reset_x0", got[0], L_DC0);

        // Asynchronous reset in the middle of the output stream
        set_impulse();
        run_block();
        repeat (3) @(negedge clk);
        reset = 1'b1;
        expq.delete();
        #1;
        chk("async_reset_oen", int'(oen), 0);
        chk("async_reset_out", int'(out_a) | int'(out_b), 0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        repeat (3) @(negedge clk);

        // Back-to-back: second start at the first IDLE edge (E16)
        set_dc();
        run_block();
        repeat (8) @(negedge clk);
        set_impulse();
        run_block();
        repeat (12) @(negedge clk);
        chk("b2b_imp_x0", got[0], L_IMP0);
        chk("b2b_imp_x1", got[1], L_IMP1);

        repeat (5) @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
